// File: rtl/decode_stage.sv
// decode_stage: RV32I (+ optional RV32M) instruction decode stage.
// An accepted request latches the fetched word and PC and presents the
// register-file read indices. On the following edge the operands are
// captured and all decode results are registered, and completed pulses
// for one cycle.
module decode_stage #(
    parameter bit ENABLE_M = 1'b1,
    parameter bit ZERO_X0  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enabled,
    output logic        completed,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [31:0] instr_raw,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] pc_out,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] rs1_val,
    output logic [31:0] rs2_val,
    output logic [31:0] imm,
    output logic        is_lui,
    output logic        is_auipc,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        is_branch,
    output logic        is_load,
    output logic        is_store,
    output logic        is_opimm,
    output logic        is_op,
    output logic        is_fence,
    output logic        is_system,
    output logic        illegal
);

    localparam logic IDLE = 1'b0;
    localparam logic READ = 1'b1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Bit positions of the class flags inside flags_c / flags_q
    localparam int C_LUI    = 0;
    localparam int C_AUIPC  = 1;
    localparam int C_JAL    = 2;
    localparam int C_JALR   = 3;
    localparam int C_BRANCH = 4;
    localparam int C_LOAD   = 5;
    localparam int C_STORE  = 6;
    localparam int C_OPIMM  = 7;
    localparam int C_OP     = 8;
    localparam int C_FENCE  = 9;
    localparam int C_SYSTEM = 10;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    logic               state;
    logic               accept;
    logic [31:0]        pc_p0;
    logic [31:0]        instr_p0;
    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [10:0]        flags_c;
    logic               legal_c;
    logic signed [31:0] imm_c;
    logic [31:0]        op1_c;
    logic [31:0]        op2_c;
    logic [10:0]        flags_q;

    assign accept = (state == IDLE) && enabled && !flush;
    assign opcode = instr_p0[6:0];
    assign f3     = instr_p0[14:12];
    assign f7     = instr_p0[31:25];

    // Latch the fetched word and PC when a request is accepted (pure data, no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_p0    <= pc;
            instr_p0 <= instr_raw;
        end
    end

    // Classify the latched word, check field legality and build the immediate.
    // Every listed opcode ends in 2'b11, so an unlisted opcode also covers
    // instr[1:0] != 2'b11.
    always_comb begin
        flags_c = '0;
        legal_c = 1'b0;
        imm_c   = '0;
        case (opcode)
            OPC_LUI: begin
                flags_c[C_LUI] = 1'b1;
                legal_c        = 1'b1;
                imm_c          = {instr_p0[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                flags_c[C_AUIPC] = 1'b1;
                legal_c          = 1'b1;
                imm_c            = {instr_p0[31:12], 12'b0};
            end
            OPC_JAL: begin
                flags_c[C_JAL] = 1'b1;
                legal_c        = 1'b1;
                imm_c          = {{12{instr_p0[31]}}, instr_p0[19:12], instr_p0[20],
                                  instr_p0[30:21], 1'b0};
            end
            OPC_JALR: begin
                flags_c[C_JALR] = 1'b1;
                legal_c         = (f3 == 3'b000);
                imm_c           = {{20{instr_p0[31]}}, instr_p0[31:20]};
            end
            OPC_BRANCH: begin
                flags_c[C_BRANCH] = 1'b1;
                legal_c           = (f3 != 3'b010) && (f3 != 3'b011);
                imm_c             = {{20{instr_p0[31]}}, instr_p0[7], instr_p0[30:25],
                                     instr_p0[11:8], 1'b0};
            end
            OPC_LOAD: begin
                flags_c[C_LOAD] = 1'b1;
                legal_c         = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                imm_c           = {{20{instr_p0[31]}}, instr_p0[31:20]};
            end
            OPC_STORE: begin
                flags_c[C_STORE] = 1'b1;
                legal_c          = (f3 < 3'b011);
                imm_c            = {{20{instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]};
            end
            OPC_OPIMM: begin
                flags_c[C_OPIMM] = 1'b1;
                if (f3 == 3'b001)
                    legal_c = (f7 == F7_BASE);
                else if (f3 == 3'b101)
                    legal_c = (f7 == F7_BASE) || (f7 == F7_ALT);
                else
                    legal_c = 1'b1;
                imm_c = {{20{instr_p0[31]}}, instr_p0[31:20]};
            end
            OPC_OP: begin
                flags_c[C_OP] = 1'b1;
                case (f7)
                    F7_BASE: legal_c = 1'b1;
                    F7_ALT:  legal_c = (f3 == 3'b000) || (f3 == 3'b101);
                    F7_MUL:  legal_c = ENABLE_M;
                    default: legal_c = 1'b0;
                endcase
            end
            OPC_FENCE: begin
                flags_c[C_FENCE] = 1'b1;
                legal_c          = 1'b1;
            end
            OPC_SYSTEM: begin
                flags_c[C_SYSTEM] = 1'b1;
                legal_c           = 1'b1;
                imm_c             = {{20{instr_p0[31]}}, instr_p0[31:20]};
            end
            default: begin
                flags_c = '0;
                legal_c = 1'b0;
            end
        endcase
    end

    // Operand selection: x0 reads as zero when ZERO_X0 is set
    always_comb begin
        op1_c = (ZERO_X0 && (rs1_addr == 5'd0)) ? 32'd0 : rs1_data;
        op2_c = (ZERO_X0 && (rs2_addr == 5'd0)) ? 32'd0 : rs2_data;
    end

    // Handshake FSM, read indices and registered decode results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            completed <= 1'b0;
            rs1_addr  <= '0;
            rs2_addr  <= '0;
            pc_out    <= '0;
            rd        <= '0;
            funct3    <= '0;
            funct7    <= '0;
            rs1_val   <= '0;
            rs2_val   <= '0;
            imm       <= '0;
            flags_q   <= '0;
            illegal   <= 1'b0;
        end else begin
            completed <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rs1_addr <= instr_raw[19:15];
                        rs2_addr <= instr_raw[24:20];
                        state    <= READ;
                    end
                end
                READ: begin
                    state <= IDLE;
                    if (!flush) begin
                        pc_out    <= pc_p0;
                        rd        <= instr_p0[11:7];
                        funct3    <= f3;
                        funct7    <= f7;
                        rs1_val   <= op1_c;
                        rs2_val   <= op2_c;
                        imm       <= imm_c;
                        flags_q   <= legal_c ? flags_c : 11'd0;
                        illegal   <= !legal_c;
                        completed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign is_lui    = flags_q[C_LUI];
    assign is_auipc  = flags_q[C_AUIPC];
    assign is_jal    = flags_q[C_JAL];
    assign is_jalr   = flags_q[C_JALR];
    assign is_branch = flags_q[C_BRANCH];
    assign is_load   = flags_q[C_LOAD];
    assign is_store  = flags_q[C_STORE];
    assign is_opimm  = flags_q[C_OPIMM];
    assign is_op     = flags_q[C_OP];
    assign is_fence  = flags_q[C_FENCE];
    assign is_system = flags_q[C_SYSTEM];

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Two instances share
// the stimulus, one with RV32M enabled and one without. Each request pushes
// the reference result into a queue; monitors pop and compare whenever an
// instance pulses completed.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc_out;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [10:0] flags;  // bit0 LUI ... bit10 SYSTEM
        logic        ill;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } res_t;

    logic        clk, rst, enabled, flush;
    logic [31:0] pc, instr_raw;
    logic [31:0] regs [32];

    logic        completed_m, completed_n;
    logic [4:0]  rs1_addr_m, rs2_addr_m, rs1_addr_n, rs2_addr_n;
    logic [31:0] rs1_data_m, rs2_data_m, rs1_data_n, rs2_data_n;
    logic [31:0] pc_out_m, rs1_val_m, rs2_val_m, imm_m;
    logic [31:0] pc_out_n, rs1_val_n, rs2_val_n, imm_n;
    logic [4:0]  rd_m, rd_n;
    logic [2:0]  funct3_m, funct3_n;
    logic [6:0]  funct7_m, funct7_n;
    logic [10:0] fl_m, fl_n;
    logic        illegal_m, illegal_n;
    res_t        act_m, act_n;

    int n_tests = 0;
    int n_fail  = 0;
    res_t q_m[$];
    res_t q_n[$];

    logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    assign rs1_data_m = regs[rs1_addr_m];
    assign rs2_data_m = regs[rs2_addr_m];
    assign rs1_data_n = regs[rs1_addr_n];
    assign rs2_data_n = regs[rs2_addr_n];

    assign act_m = {pc_out_m, rd_m, funct3_m, funct7_m, rs1_val_m, rs2_val_m, imm_m,
                    fl_m, illegal_m, rs1_addr_m, rs2_addr_m};
    assign act_n = {pc_out_n, rd_n, funct3_n, funct7_n, rs1_val_n, rs2_val_n, imm_n,
                    fl_n, illegal_n, rs1_addr_n, rs2_addr_n};

    decode_stage #(.ENABLE_M(1'b1), .ZERO_X0(1'b1)) dut_m (
        .clk(clk), .rst(rst), .enabled(enabled), .completed(completed_m), .flush(flush),
        .pc(pc), .instr_raw(instr_raw), .rs1_addr(rs1_addr_m), .rs2_addr(rs2_addr_m),
        .rs1_data(rs1_data_m), .rs2_data(rs2_data_m), .pc_out(pc_out_m), .rd(rd_m),
        .funct3(funct3_m), .funct7(funct7_m), .rs1_val(rs1_val_m), .rs2_val(rs2_val_m),
        .imm(imm_m), .is_lui(fl_m[0]), .is_auipc(fl_m[1]), .is_jal(fl_m[2]),
        .is_jalr(fl_m[3]), .is_branch(fl_m[4]), .is_load(fl_m[5]), .is_store(fl_m[6]),
        .is_opimm(fl_m[7]), .is_op(fl_m[8]), .is_fence(fl_m[9]), .is_system(fl_m[10]),
        .illegal(illegal_m)
    );

    decode_stage #(.ENABLE_M(1'b0), .ZERO_X0(1'b1)) dut_n (
        .clk(clk), .rst(rst), .enabled(enabled), .completed(completed_n), .flush(flush),
        .pc(pc), .instr_raw(instr_raw), .rs1_addr(rs1_addr_n), .rs2_addr(rs2_addr_n),
        .rs1_data(rs1_data_n), .rs2_data(rs2_data_n), .pc_out(pc_out_n), .rd(rd_n),
        .funct3(funct3_n), .funct7(funct7_n), .rs1_val(rs1_val_n), .rs2_val(rs2_val_n),
        .imm(imm_n), .is_lui(fl_n[0]), .is_auipc(fl_n[1]), .is_jal(fl_n[2]),
        .is_jalr(fl_n[3]), .is_branch(fl_n[4]), .is_load(fl_n[5]), .is_store(fl_n[6]),
        .is_opimm(fl_n[7]), .is_op(fl_n[8]), .is_fence(fl_n[9]), .is_system(fl_n[10]),
        .illegal(illegal_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Sign-extend the low 'bits' bits of v by arithmetic shifting
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic signed [31:0] t;
        t = v << (32 - bits);
        return t >>> (32 - bits);
    endfunction

    // Reference decode from the instruction-set rules
    function automatic res_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                        input bit en_m);
        res_t r;
        int   cls;
        bit   ok;
        logic [2:0] f3;
        logic [6:0] f7;
        f3  = ins[14:12];
        f7  = ins[31:25];
        cls = -1;
        for (int i = 0; i < 11; i++)
            if (ins[6:0] == opcs[i]) cls = i;
        ok = (cls >= 0) && (ins[1:0] == 2'b11);
        case (cls)
            3: ok = ok && (f3 == 0);
            4: ok = ok && !(f3 == 2 || f3 == 3);
            5: ok = ok && !(f3 == 3 || f3 >= 6);
            6: ok = ok && (f3 <= 2);
            7: if (f3 == 1) ok = ok && (f7 == 0);
               else if (f3 == 5) ok = ok && (f7 == 0 || f7 == 7'h20);
            8: ok = ok && ((f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) ||
                           (f7 == 7'h01 && en_m));
            default: ;
        endcase
        case (cls)
            0, 1:        r.imm = {ins[31:12], 12'h000};
            2:           r.imm = sext({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
            3, 5, 7, 10: r.imm = sext({20'd0, ins[31:20]}, 12);
            4:           r.imm = sext({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
            6:           r.imm = sext({20'd0, ins[31:25], ins[11:7]}, 12);
            default:     r.imm = 32'd0;
        endcase
        r.pc_out = p;
        r.rd     = ins[11:7];
        r.f3     = f3;
        r.f7     = f7;
        r.a1     = ins[19:15];
        r.a2     = ins[24:20];
        r.v1     = (r.a1 == 0) ? 32'd0 : regs[r.a1];
        r.v2     = (r.a2 == 0) ? 32'd0 : regs[r.a2];
        r.flags  = ok ? (11'b1 << cls) : 11'd0;
        r.ill    = !ok;
        return r;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic check_res(input string tag, input res_t a, input res_t e,
                             input bit skip_addr);
        cmp({tag, ".pc_out"}, a.pc_out, e.pc_out);
        cmp({tag, ".rd"}, 32'(a.rd), 32'(e.rd));
        cmp({tag, ".funct3"}, 32'(a.f3), 32'(e.f3));
        cmp({tag, ".funct7"}, 32'(a.f7), 32'(e.f7));
        cmp({tag, ".rs1_val"}, a.v1, e.v1);
        cmp({tag, ".rs2_val"}, a.v2, e.v2);
        if (!e.ill) cmp({tag, ".imm"}, a.imm, e.imm);
        cmp({tag, ".flags"}, 32'(a.flags), 32'(e.flags));
        cmp({tag, ".illegal"}, 32'(a.ill), 32'(e.ill));
        if (!skip_addr) begin
            cmp({tag, ".rs1_addr"}, 32'(a.a1), 32'(e.a1));
            cmp({tag, ".rs2_addr"}, 32'(a.a2), 32'(e.a2));
        end
    endtask

    // Monitor for the RV32M-enabled instance
    always @(negedge clk) begin
        if (completed_m) begin
            if (q_m.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_completed_m: got 1 expected 0");
            end else begin
                check_res("m", act_m, q_m.pop_front(), 1'b0);
            end
        end
    end

    // Monitor for the RV32M-disabled instance
    always @(negedge clk) begin
        if (completed_n) begin
            if (q_n.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_completed_n: got 1 expected 0");
            end else begin
                check_res("n", act_n, q_n.pop_front(), 1'b0);
            end
        end
    end

    // One request: drive, then check the completion timing
    task automatic do_op(input logic [31:0] ins, input logic [31:0] p);
        @(negedge clk);
        enabled   = 1'b1;
        instr_raw = ins;
        pc        = p;
        q_m.push_back(ref_decode(ins, p, 1'b1));
        q_n.push_back(ref_decode(ins, p, 1'b0));
        @(negedge clk);
        enabled   = 1'b0;
        instr_raw = $urandom();
        pc        = $urandom();
        cmp("completed_early", 32'(completed_m), 32'd0);
        @(negedge clk);
        cmp("completed_latency", 32'(completed_m), 32'd1);
        cmp("completed_latency_n", 32'(completed_n), 32'd1);
        @(negedge clk);
        cmp("completed_width", 32'(completed_m), 32'd0);
    endtask

    initial begin
        res_t        last;
        logic [31:0] w, ins;
        logic [4:0]  held_a1;
        int          cnt;
        bit          prev;

        rst = 1'b1; enabled = 1'b0; flush = 1'b0; pc = '0; instr_raw = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom();
        regs[0] = 32'hDEADBEEF;
        regs[1] = 32'h0000_1000;
        regs[2] = 32'h0000_0055;

        #12;
        cmp("reset_completed", 32'(completed_m), 32'd0);
        check_res("reset_m", act_m, '0, 1'b0);
        check_res("reset_n", act_n, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        do_op(32'hFFF00093, 32'h100);
        cmp("addi_imm", imm_m, 32'hFFFFFFFF);
        cmp("addi_rs1_x0", rs1_val_m, 32'd0);
        do_op(32'h0020A423, 32'h104);
        cmp("sw_rs1_val", rs1_val_m, 32'h1000);
        cmp("sw_imm", imm_m, 32'h8);
        do_op(32'hFE000EE3, 32'h108);
        cmp("beq_imm", imm_m, 32'hFFFFFFFC);
        do_op(32'h123452B7, 32'h10C);
        cmp("lui_imm", imm_m, 32'h12345000);
        do_op(32'h00000000, 32'h110);
        cmp("zero_illegal", 32'(illegal_m), 32'd1);
        do_op(32'h02208033, 32'h114);
        cmp("mul_is_op_m", 32'(fl_m[8]), 32'd1);
        cmp("mul_illegal_n", 32'(illegal_n), 32'd1);

        // enabled held high for six cycles: one completion every two cycles
        @(negedge clk);
        enabled   = 1'b1;
        instr_raw = 32'h00308133;
        pc        = 32'h200;
        for (int i = 0; i < 3; i++) begin
            q_m.push_back(ref_decode(instr_raw, pc, 1'b1));
            q_n.push_back(ref_decode(instr_raw, pc, 1'b0));
        end
        cnt  = 0;
        prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (completed_m) cnt++;
            if (completed_m && prev) begin
                n_tests++;
                n_fail++;
                $display("FAIL back_to_back_completed: got 1 expected 0");
            end
            prev = completed_m;
        end
        enabled = 1'b0;
        cmp("held_enable_pulses", 32'(cnt), 32'd3);

        // flush while in READ: no completion, decode outputs unchanged
        do_op(32'h00A00513, 32'h300);
        last = ref_decode(32'h00A00513, 32'h300, 1'b1);
        @(negedge clk);
        enabled   = 1'b1;
        instr_raw = 32'h0041A283;
        pc        = 32'h304;
        @(negedge clk);
        enabled = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cmp("flush_read_no_pulse", 32'(completed_m), 32'd0);
        check_res("flush_hold", act_m, last, 1'b1);
        @(negedge clk);
        cmp("flush_read_no_pulse2", 32'(completed_m), 32'd0);

        // flush together with enabled in IDLE: request dropped
        held_a1 = rs1_addr_m;
        @(negedge clk);
        enabled   = 1'b1;
        flush     = 1'b1;
        instr_raw = {7'd0, 5'd15, 5'd15, 3'd0, 5'd15, 7'h33};
        @(negedge clk);
        enabled = 1'b0;
        flush   = 1'b0;
        cmp("flush_idle_addr", 32'(rs1_addr_m), 32'(held_a1));
        @(negedge clk);
        cmp("flush_idle_no_pulse", 32'(completed_m), 32'd0);
        @(negedge clk);
        cmp("flush_idle_no_pulse2", 32'(completed_m), 32'd0);

        // Reset while in READ clears everything without a clock edge
        @(negedge clk);
        enabled   = 1'b1;
        instr_raw = 32'h12345637;
        pc        = 32'h400;
        @(posedge clk);
        #2;
        enabled = 1'b0;
        rst     = 1'b1;
        #1;
        cmp("rst_mid_completed", 32'(completed_m), 32'd0);
        check_res("rst_mid_m", act_m, '0, 1'b0);
        check_res("rst_mid_n", act_n, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("rst_mid_no_pulse", 32'(completed_m), 32'd0);
        do_op(32'h0020A423, 32'h500);

        // Randomized instructions, biased toward listed opcodes and funct7 corners
        for (int i = 0; i < 200; i++) begin
            int sel;
            int k;
            w   = $urandom();
            ins = w;
            sel = $urandom_range(0, 15);
            if (sel != 0) ins[6:0] = opcs[$urandom_range(0, 10)];
            if (sel >= 8) begin
                k = $urandom_range(0, 2);
                ins[31:25] = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'h01;
            end
            do_op(ins, $urandom() & 32'hFFFF_FFFC);
        end

        repeat (3) @(negedge clk);
        cmp("queue_m_drained", 32'(q_m.size()), 32'd0);
        cmp("queue_n_drained", 32'(q_n.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
